// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, state codes and address helpers for the NTT scheduler
package ntt_pkg;
    localparam int N     = 256;
    localparam int LOGN  = 8;
    localparam int PIPE  = 8;
    localparam int STG_W = $clog2(LOGN);
    localparam int K_W   = LOGN - 2;
    localparam int DRN_W = $clog2(PIPE + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Butterfly j of stage s sits in group j>>sh; each group spans 2h addresses with h = 1<<sh.
    function automatic logic [LOGN-1:0] top_addr(input logic [LOGN-1:0] j,
                                                  input logic [STG_W-1:0] s);
        logic [STG_W-1:0] sh;
        logic [LOGN-1:0]  mask;
        sh   = STG_W'(LOGN - 1) - s;
        mask = (LOGN'(1) << sh) - LOGN'(1);
        return (((j >> sh) << 1) << sh) | (j & mask);
    endfunction

    function automatic logic [LOGN-1:0] tw_index(input logic [LOGN-1:0] j,
                                                  input logic [STG_W-1:0] s);
        logic [STG_W-1:0] sh;
        sh = STG_W'(LOGN - 1) - s;
        return (LOGN'(1) << s) + (j >> sh);
    endfunction
endpackage

// File: rtl/ntt_addr_sched_if.sv
// rtl/ntt_addr_sched_if.sv - control and address bundle between scheduler and NTT datapath
interface ntt_addr_sched_if;
    import ntt_pkg::*;
    logic             start;
    logic             busy;
    logic             done;
    logic [STG_W-1:0] stage;
    logic             rd_en;
    logic [LOGN-1:0]  rd_a0;
    logic [LOGN-1:0]  rd_a1;
    logic [LOGN-1:0]  tw0;
    logic [LOGN-1:0]  tw1;
    logic             wr_en;
    logic [LOGN-1:0]  wr_a0;
    logic [LOGN-1:0]  wr_a1;

    modport master (input start, output busy, done, stage, rd_en, rd_a0, rd_a1,
                    tw0, tw1, wr_en, wr_a0, wr_a1);
    modport slave  (output start, input busy, done, stage, rd_en, rd_a0, rd_a1,
                    tw0, tw1, wr_en, wr_a0, wr_a1);
endinterface

// File: rtl/ntt_delay_line.sv
// rtl/ntt_delay_line.sv - resettable fixed-depth register chain
module ntt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[DEPTH-1];
endmodule

// File: rtl/ntt_addr_sched.sv
// rtl/ntt_addr_sched.sv - stage/butterfly sequencer issuing two butterflies per cycle
module ntt_addr_sched
    import ntt_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    ntt_addr_sched_if.master  bus
);
    logic [1:0]       r_state, w_nxt_state;
    logic [STG_W-1:0] r_stage, w_nxt_stage;
    logic [K_W-1:0]   r_k, w_nxt_k;
    logic [DRN_W-1:0] r_drain, w_nxt_drain;
    logic             r_rd_en;
    logic [LOGN-1:0]  r_rd_a0, r_rd_a1, r_tw0, r_tw1;
    logic [LOGN-1:0]  w_j0, w_j1;
    logic [2*LOGN:0]  w_wr;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_stage = r_stage;
        w_nxt_k     = r_k;
        w_nxt_drain = r_drain;
        case (r_state)
            S_IDLE: if (bus.start) begin
                w_nxt_state = S_RUN;
                w_nxt_stage = '0;
                w_nxt_k     = '0;
            end
            S_RUN: if (r_k == K_W'(N/4 - 1)) begin
                w_nxt_state = S_DRAIN;
                w_nxt_drain = '0;
            end else begin
                w_nxt_k = r_k + K_W'(1);
            end
            S_DRAIN: if (r_drain == DRN_W'(PIPE - 1)) begin
                if (r_stage == STG_W'(LOGN - 1)) begin
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_state = S_RUN;
                    w_nxt_stage = r_stage + STG_W'(1);
                    w_nxt_k     = '0;
                end
            end else begin
                w_nxt_drain = r_drain + DRN_W'(1);
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Addresses are computed from the next-state counters so they register alongside rd_en.
    assign w_j0 = LOGN'({w_nxt_k, 1'b0});
    assign w_j1 = w_j0 | LOGN'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_drain <= '0;
            r_rd_en <= 1'b0;
            r_rd_a0 <= '0;
            r_rd_a1 <= '0;
            r_tw0   <= '0;
            r_tw1   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_stage <= w_nxt_stage;
            r_k     <= w_nxt_k;
            r_drain <= w_nxt_drain;
            r_rd_en <= (w_nxt_state == S_RUN);
            if (w_nxt_state == S_RUN) begin
                r_rd_a0 <= top_addr(w_j0, w_nxt_stage);
                r_rd_a1 <= top_addr(w_j1, w_nxt_stage);
                r_tw0   <= tw_index(w_j0, w_nxt_stage);
                r_tw1   <= tw_index(w_j1, w_nxt_stage);
            end else begin
                r_rd_a0 <= '0;
                r_rd_a1 <= '0;
                r_tw0   <= '0;
                r_tw1   <= '0;
            end
        end
    end

    ntt_delay_line #(.WIDTH(1 + 2*LOGN), .DEPTH(PIPE)) u_wr_dly (
        .clk    (clk),
        .rstn   (rstn),
        .i_data ({r_rd_en, r_rd_a0, r_rd_a1}),
        .o_data (w_wr)
    );

    assign bus.busy  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done  = (r_state == S_DONE);
    assign bus.stage = r_stage;
    assign bus.rd_en = r_rd_en;
    assign bus.rd_a0 = r_rd_a0;
    assign bus.rd_a1 = r_rd_a1;
    assign bus.tw0   = r_tw0;
    assign bus.tw1   = r_tw1;
    assign bus.wr_en = w_wr[2*LOGN];
    assign bus.wr_a0 = w_wr[2*LOGN-1:LOGN];
    assign bus.wr_a1 = w_wr[LOGN-1:0];
endmodule

// File: tb/tb_ntt_addr_sched.sv
// tb/tb_ntt_addr_sched.sv - randomized self-checking bench for ntt_addr_sched
module tb_ntt_addr_sched;
    import ntt_pkg::*;

    localparam int PER   = N/4 + PIPE;
    localparam int TDONE = 1 + LOGN*PER;
    localparam int TEND  = TDONE + 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ntt_addr_sched_if bus();
    ntt_addr_sched dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cov [LOGN][N];
    bit spur [TEND+1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_addr(input int j, input int s);
        int h;
        h = N >> (s + 1);
        return (j / h) * 2 * h + (j % h);
    endfunction

    function automatic int ref_tw(input int j, input int s);
        return (1 << s) + j / (N >> (s + 1));
    endfunction

    function automatic logic [63:0] pack(input logic bsy, input logic dn, input int st,
            input logic rd, input int a0, input int a1, input int t0, input int t1,
            input logic wr, input int w0, input int w1);
        return {9'd0, bsy, dn, STG_W'(st), rd, LOGN'(a0), LOGN'(a1), LOGN'(t0), LOGN'(t1),
                wr, LOGN'(w0), LOGN'(w1)};
    endfunction

    function automatic logic [63:0] obs_vec(input bit no_stage);
        return pack(bus.busy, bus.done, no_stage ? 0 : int'(bus.stage), bus.rd_en,
                    int'(bus.rd_a0), int'(bus.rd_a1), int'(bus.tw0), int'(bus.tw1),
                    bus.wr_en, int'(bus.wr_a0), int'(bus.wr_a1));
    endfunction

    // Expected outputs t cycles after the start edge, derived from stage period arithmetic.
    function automatic logic [63:0] model(input int t, input bit no_stage);
        logic bsy, dn, rd, wr;
        int s, p, tr, st, a0, a1, t0, t1, w0, w1;
        bsy = (t >= 1) && (t < TDONE);
        dn  = (t == TDONE);
        rd = 0; wr = 0; st = 0; a0 = 0; a1 = 0; t0 = 0; t1 = 0; w0 = 0; w1 = 0;
        if (bsy) begin
            s = (t - 1) / PER; p = (t - 1) % PER; st = s;
            if (p < N/4) begin
                rd = 1;
                a0 = ref_addr(2*p, s);   a1 = ref_addr(2*p + 1, s);
                t0 = ref_tw(2*p, s);     t1 = ref_tw(2*p + 1, s);
            end
        end
        tr = t - PIPE;
        if (tr >= 1 && tr < TDONE) begin
            s = (tr - 1) / PER; p = (tr - 1) % PER;
            if (p < N/4) begin
                wr = 1;
                w0 = ref_addr(2*p, s);   w1 = ref_addr(2*p + 1, s);
            end
        end
        if (no_stage) st = 0;
        return pack(bsy, dn, st, rd, a0, a1, t0, t1, wr, w0, w1);
    endfunction

    task automatic launch();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic plan_checks(input int t);
        if (t == 1) begin
            chk("c1_rd", {bus.rd_en, bus.stage, bus.rd_a0, bus.rd_a1}, {1'b1, 3'd0, 8'd0, 8'd1});
            chk("c1_tw", {bus.tw0, bus.tw1}, {8'd1, 8'd1});
        end
        if (t == 9)
            chk("c9_wr", {bus.wr_en, bus.wr_a0, bus.wr_a1}, {1'b1, 8'd0, 8'd1});
        if (t == 1 + PER + 32)
            chk("s1k32", {bus.rd_a0, bus.rd_a1, bus.tw0, bus.tw1}, {8'd128, 8'd129, 8'd3, 8'd3});
        if (t == 1 + 7*PER)
            chk("s7k0", {bus.rd_a0, bus.rd_a1, bus.tw0, bus.tw1}, {8'd0, 8'd2, 8'd128, 8'd129});
        if (t == 1 + 7*PER + 63)
            chk("s7k63", {bus.rd_a0, bus.rd_a1, bus.tw0, bus.tw1}, {8'd252, 8'd254, 8'd254, 8'd255});
    endtask

    task automatic run_full(input int n_spur);
        int rd_cnt, wr_cnt, dn_cnt, bad, s, h;
        rd_cnt = 0; wr_cnt = 0; dn_cnt = 0; bad = 0;
        for (int i = 0; i <= TEND; i++) spur[i] = 0;
        spur[5] = 1; spur[300] = 1;
        for (int i = 0; i < n_spur; i++) spur[$urandom_range(2, TDONE)] = 1;
        for (int s2 = 0; s2 < LOGN; s2++) for (int a = 0; a < N; a++) cov[s2][a] = 0;
        launch();
        for (int t = 1; t <= TEND; t++) begin
            chk($sformatf("cyc%0d", t), obs_vec(t >= TDONE), model(t, t >= TDONE));
            plan_checks(t);
            rd_cnt += int'(bus.rd_en);
            wr_cnt += int'(bus.wr_en);
            dn_cnt += int'(bus.done);
            if (bus.rd_en && t < TDONE) begin
                s = (t - 1) / PER; h = N >> (s + 1);
                cov[s][bus.rd_a0]++; cov[s][(int'(bus.rd_a0) + h) % N]++;
                cov[s][bus.rd_a1]++; cov[s][(int'(bus.rd_a1) + h) % N]++;
            end
            bus.start = spur[t];
            @(negedge clk);
        end
        bus.start = 1'b0;
        for (int s2 = 0; s2 < LOGN; s2++)
            for (int a = 0; a < N; a++) if (cov[s2][a] != 1) bad++;
        chk("rd_count", 64'(rd_cnt), 64'(LOGN*N/4));
        chk("wr_count", 64'(wr_cnt), 64'(LOGN*N/4));
        chk("done_count", 64'(dn_cnt), 64'd1);
        chk("addr_cover_bad", 64'(bad), 64'd0);
    endtask

    task automatic run_reset();
        int act;
        act = 0;
        launch();
        for (int t = 1; t <= 100; t++) begin
            chk($sformatf("pre_rst%0d", t), obs_vec(1'b0), model(t, 1'b0));
            if (t < 100) @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        chk("rst_async", obs_vec(1'b0), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            act += int'(bus.rd_en) + int'(bus.wr_en) + int'(bus.busy) + int'(bus.done);
        end
        chk("post_rst_quiet", 64'(act), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        #12;
        chk("reset_state", obs_vec(1'b0), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_state", obs_vec(1'b0), 64'd0);
        run_full($urandom_range(3, 10));
        repeat ($urandom_range(2, 6)) @(negedge clk);
        run_reset();
        run_full($urandom_range(3, 10));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_addr_sched.md
Name: ntt_addr_sched

Overview:
- Sequencing controller for the NTT core's two parallel butterfly units (BFU0, BFU1).
- On a start pulse it walks all LOGN Cooley-Tukey stages and issues two butterflies per cycle.
- It generates the read top-addresses and twiddle indices, then replays them as write-back addresses once the fixed BFU pipeline latency has elapsed.
- It drains the pipeline between stages so that the next stage never reads stale data.

Parameters:
- N, 256, transform length (power of two, at least 8)
- LOGN, 8, log2(N); also the width of data and twiddle addresses
- PIPE, 8, BFU read-to-write latency in cycles (at least 1)
- STG_W, 3, stage counter width, equal to clog2(LOGN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; honoured only in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  1-cycle pulse at completion
- stage  out  STG_W  current stage index s
- rd_en  out  1  read issue strobe
- rd_a0  out  LOGN  BFU0 top address a (the partner address is a+h, formed by the memory wrapper)
- rd_a1  out  LOGN  BFU1 top address
- tw0  out  LOGN  BFU0 twiddle index
- tw1  out  LOGN  BFU1 twiddle index
- wr_en  out  1  rd_en delayed by PIPE cycles
- wr_a0  out  LOGN  rd_a0 delayed by PIPE cycles
- wr_a1  out  LOGN  rd_a1 delayed by PIPE cycles

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous and active-low. With rstn=0, every register and every output is 0 and the state is IDLE. This also clears the delay line, so no spurious wr_en appears after a mid-operation reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on an edge with start=1; stage=0, k=0.
  - RUN: rd_en=1 every cycle. k counts 0..N/4-1. When k=N/4-1: state -> DRAIN and the drain counter is set to 0.
  - DRAIN: rd_en=0 for exactly PIPE cycles. On the last drain cycle: if stage=LOGN-1, go to DONE; otherwise stage+1, k=0, and go to RUN.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while not in IDLE is ignored; it is neither queued nor a restart.
- Butterfly indices in a RUN cycle: j0=2k and j1=2k+1, with h = N>>(s+1).
- Top address: a(j) = ((j >> (LOGN-1-s)) << (LOGN-s)) | (j & (h-1)).
- Twiddle index: tw(j) = (1<<s) + (j >> (LOGN-1-s)), computed in LOGN bits; the maximum is N-1, so there is no overflow.
- rd_a0/rd_a1/tw0/tw1 are registered and valid in the same cycle as rd_en. When rd_en=0 they hold 0.
- Write-back path: wr_en, wr_a0 and wr_a1 equal rd_en, rd_a0 and rd_a1 from exactly PIPE cycles earlier.
  - The last write of a stage lands in the final DRAIN cycle.
  - The first read of the next stage follows one cycle later (read-after-write safe).
- Timing, assuming the start edge is cycle 0:
  - first rd_en in cycle 1;
  - stage period is N/4+PIPE cycles (72 for the defaults);
  - done in cycle 1 + LOGN*(N/4+PIPE), which is 577 for the defaults.
- busy falls in the same cycle that done rises.

Decomposition:
- Shared package ntt_pkg holds:
  - constants N, LOGN, PIPE and STG_W;
  - the state encoding localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- Sub-module ntt_delay_line(WIDTH, DEPTH): a resettable DEPTH-stage register chain. It is instantiated once with WIDTH=1+2*LOGN and DEPTH=PIPE, and carries {rd_en, rd_a0, rd_a1}.

Test Plan:
- Reset then start at cycle 0 -> cycle 1: rd_en=1, stage=0, rd_a0=0, rd_a1=1, tw0=tw1=1. Cycle 9: wr_en=1, wr_a0=0, wr_a1=1.
- Stage 1, k=32 -> rd_a0=128, rd_a1=129, tw0=tw1=3.
- Stage 7, k=0 -> rd_a0=0, rd_a1=2, tw0=128, tw1=129. Stage 7, k=63 -> rd_a0=252, rd_a1=254, tw0=254, tw1=255.
- Full run -> exactly 8*64 rd_en cycles and 512 wr_en cycles. Each address 0..255 appears once as a top or partner address per stage. done is high only in cycle 577; busy is low afterwards.
- start pulsed in cycles 5 and 300 during a run -> no effect; done still in cycle 577.
- rstn low in cycle 100 for 2 cycles -> all outputs 0 immediately and no wr_en afterwards. A new start then yields first rd_en one cycle later with stage=0.
